alu_mp_seq: RTL and testbench
=============================

# alu_mp_seq

Multi-precision sequencer for the 8-bit combinational ALU. It accepts BYTES-wide operands and an operation over a start/done handshake, then steps the ALU one byte per cycle, least-significant byte first, chaining carry between bytes. It sits beside the ALU instance and drives the ALU's control, operand and carry-in inputs directly, so wide ADD/SUB/AND/OR/NOT complete with no wider adder.

## Interface
Parameters:
- BYTES, 4, operand width in bytes (≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only while ready=1.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT(opa); 5–7 illegal.
- opa  in  8*BYTES  operand A.
- opb  in  8*BYTES  operand B.
- ready  out  1  idle, start accepted.
- done  out  1  one-cycle completion pulse.
- result  out  8*BYTES  last completed result; held until next completion.
- carry_out  out  1  final carry (ADD), no-borrow (SUB), 0 otherwise.
- zero  out  1  result==0, updated with result.
- alu_ctrl  out  4  to ALU ctrl_input (kAddC, kAnd, kOr, kNeg).
- alu_a, alu_b  out  8  to ALU a, b.
- alu_cin  out  1  to ALU cin.
- alu_out  in  8  from ALU out.
- alu_cout  in  1  from ALU cout.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, latch op, opa and opb, and set idx=0. Set carry reg = (op==SUB). Clear work reg, then go to RUN.
- RUN: alu_a=opa byte[idx]. alu_b=opb byte[idx], inverted for SUB. alu_cin=carry reg.
  - Each cycle, write alu_out into work byte[idx].
  - For ADD/SUB, carry reg ← alu_cout.
  - idx increments. After the idx=BYTES-1 cycle, go to DONE.
- ALU control by op:
  - ADD and SUB use kAddC. SUB is A + ~B + 1.
  - AND uses kAnd. OR uses kOr. NOT uses kNeg.
  - Illegal ops drive kAnd and write 0x00 bytes.
- DONE:
  - Assert done=1 for one cycle.
  - Copy work→result and set zero=(work==0).
  - Set carry_out to carry reg for ADD/SUB, 0 otherwise.
  - Return to IDLE.
- start is ignored in RUN and DONE. No queuing.
- Outputs are registered except the alu_* drives, which are combinational from the state, idx and latched operands.
- In IDLE and DONE, alu_* outputs are driven 0.
- Reset values:
  - State IDLE, ready=1, done=0.
  - result=0, carry_out=0, zero=1.
  - alu_ctrl, alu_a, alu_b and alu_cin are 0. idx, work and carry reg are 0.
- Reset mid-RUN: abort to IDLE on the next edge. No done pulse. result is cleared per the reset values.
- idx width is clog2(BYTES). Byte slices are [8*idx+7 : 8*idx]. There is no wrap, because the RUN exit is at idx=BYTES-1.

## Timing
- start accepted at edge E0. RUN occupies cycles E0+1 … E0+BYTES. done=1 in cycle E0+BYTES+1. ready=1 again from E0+BYTES+2.
- Latency from start to done is BYTES+1 cycles. Throughput is one operation per BYTES+2 cycles.
- result, zero and carry_out change on the edge that enters DONE and are valid while done=1.
- alu_out and alu_cout are sampled in the same cycle they are driven, because the ALU is combinational.

## Configuration
- ALU_SEQ_ABORT_EN defined: adds input port abort (1 bit).
  - abort=1 in RUN returns to IDLE on the next edge.
  - No done pulse. result, zero and carry_out keep their previous values; the work reg is discarded.
  - abort in IDLE or DONE has no effect.
  - If start and abort are both high in IDLE, start wins.
- ALU_SEQ_ABORT_EN undefined: no abort port. RUN always completes.

## Test plan
- ADD, BYTES=4: 0x000000FF + 0x00000001 → result 0x00000100, carry_out 0, zero 0. done exactly 5 cycles after the start edge. ready low for cycles 1–5.
- ADD overflow: 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry_out 1, zero 1.
- SUB: 0x00000005 − 0x00000007 → 0xFFFFFFFE, carry_out 0. 0x00000007 − 0x00000005 → 0x00000002, carry_out 1.
- Logic ops on opa 0xF0F0A5A5, opb 0x0FF0FF00:
  - AND → 0x00F0A500.
  - OR → 0xFFF0FFA5.
  - NOT → 0x0F0F5A5A.
  - op=6 → 0x00000000.
  - carry_out 0 in all cases.
- Busy and reset:
  - start pulsed during RUN is ignored: the result is that of the first operation, with one done pulse.
  - reset asserted in the 2nd RUN cycle → next cycle IDLE, ready=1, result 0, zero 1, no done.
- With ALU_SEQ_ABORT_EN: complete ADD 1+1 (result 2), then start 0xFF+1 and abort in the 2nd RUN cycle → no done, result stays 0x00000002, ready=1 the next cycle.

Source files
------------

// File: rtl/alu_mp_seq.sv
// alu_mp_seq: multi-precision sequencer for an external 8-bit combinational ALU.
// Steps BYTES-wide operands through the ALU one byte per cycle, LSB first,
// chaining carry between bytes.
// Optional feature: define ALU_SEQ_ABORT_EN to add an abort input that
// cancels a RUN in progress without updating result/zero/carry_out.
module alu_mp_seq #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [8*BYTES-1:0]   opa,
    input  logic [8*BYTES-1:0]   opb,
`ifdef ALU_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 ready,
    output logic                 done,
    output logic [8*BYTES-1:0]   result,
    output logic                 carry_out,
    output logic                 zero,
    output logic [3:0]           alu_ctrl,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic                 alu_cin,
    input  logic [7:0]           alu_out,
    input  logic                 alu_cout
);
    localparam int W  = 8 * BYTES;
    localparam int IW = $clog2(BYTES);

    // ALU control encodings (ALU ctrl_input); 0 is the idle drive
    localparam logic [3:0] K_ADDC = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_NEG  = 4'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [W-1:0]   work_q, work_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_out_q, carry_out_d;
    logic           zero_q, zero_d;

    logic [7:0]     a_byte, b_byte, byte_res;
    logic           is_arith, is_legal;

    assign a_byte   = opa_q[{idx_q, 3'b000} +: 8];
    assign b_byte   = opb_q[{idx_q, 3'b000} +: 8];
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_legal = (op_q <= OP_NOT);
    // illegal ops still run the ALU (as AND) but contribute zero bytes
    assign byte_res = is_legal ? alu_out : 8'h00;

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;

    // ALU drives: combinational from state, idx and latched operands
    always_comb begin
        alu_ctrl = 4'd0;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_cin  = 1'b0;
        if (state_q == RUN) begin
            alu_a   = a_byte;
            alu_b   = b_byte;
            alu_cin = carry_q;
            case (op_q)
                OP_ADD:  alu_ctrl = K_ADDC;
                OP_SUB: begin
                    alu_ctrl = K_ADDC;
                    alu_b    = ~b_byte;
                end
                OP_AND:  alu_ctrl = K_AND;
                OP_OR:   alu_ctrl = K_OR;
                OP_NOT:  alu_ctrl = K_NEG;
                default: alu_ctrl = K_AND;
            endcase
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        work_d      = work_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    opa_d   = opa;
                    opb_d   = opb;
                    idx_d   = '0;
                    carry_d = (op == OP_SUB);
                    work_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[{idx_q, 3'b000} +: 8] = byte_res;
                if (is_arith) carry_d = alu_cout;
                if (idx_q == IW'(BYTES - 1)) begin
                    // result is published on the edge entering DONE,
                    // so it includes the byte written this cycle
                    state_d     = DONE;
                    result_d    = work_d;
                    zero_d      = (work_d == '0);
                    carry_out_d = is_arith ? carry_d : 1'b0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
`ifdef ALU_SEQ_ABORT_EN
                if (abort) begin
                    state_d     = IDLE;
                    result_d    = result_q;
                    zero_d      = zero_q;
                    carry_out_d = carry_out_q;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_mp_seq.sv
// tb_alu_mp_seq: self-checking bench for alu_mp_seq with a behavioural
// 8-bit ALU on the alu_* port and a whole-word reference model.
module tb_alu_mp_seq;
    localparam int BYTES = 4;
    localparam int W = 8 * BYTES;
    localparam logic [3:0] K_ADDC = 4'd1, K_AND = 4'd2, K_OR = 4'd3, K_NEG = 4'd4;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [2:0] op = '0;
    logic [W-1:0] opa = '0, opb = '0;
    logic ready, done, carry_out, zero, alu_cin, alu_cout;
    logic [W-1:0] result;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_a, alu_b, alu_out;

    int chk = 0;
    int errs = 0;

    always #5 clk = ~clk;

    alu_mp_seq #(.BYTES(BYTES)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
`ifdef ALU_SEQ_ABORT_EN
        .abort(abort),
`endif
        .ready(ready), .done(done), .result(result), .carry_out(carry_out),
        .zero(zero), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout)
    );

    // Behavioural 8-bit combinational ALU
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
        alu_out  = 8'h00;
        alu_cout = 1'b0;
        case (alu_ctrl)
            K_ADDC: begin alu_out = alu_sum[7:0]; alu_cout = alu_sum[8]; end
            K_AND:  alu_out = alu_a & alu_b;
            K_OR:   alu_out = alu_a | alu_b;
            K_NEG:  alu_out = ~alu_a;
            default: alu_out = 8'h00;
        endcase
    end

    // Whole-word reference: what the sequencer must produce for one operation
    function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] r,
                                      output logic c);
        logic [W:0] full;
        r = '0; c = 1'b0;
        case (o)
            3'd0: begin full = {1'b0, a} + {1'b0, b}; r = full[W-1:0]; c = full[W]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~a;
            default: r = '0;
        endcase
    endfunction

    // Issue one operation from IDLE and wait for done; returns values seen
    // during the done cycle, then steps into IDLE.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic c, output logic z,
                          output int cycles);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        while (!done && cycles <= 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        r = result; c = carry_out; z = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", ready); end
        chk++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", done); end
        chk++; if (result !== '0 || carry_out !== 1'b0 || zero !== 1'b1) begin
            errs++; $display("FAIL reset_outs got r=%h c=%b z=%b exp r=0 c=0 z=1", result, carry_out, zero); end
        chk++; if ({alu_ctrl, alu_a, alu_b, alu_cin} !== '0) begin
            errs++; $display("FAIL reset_alu got ctrl=%h a=%h b=%h cin=%b exp 0", alu_ctrl, alu_a, alu_b, alu_cin); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_timing();
        int done_cnt = 0, done_at = -1, ready_bad = 0;
        op = 3'd0; opa = 32'h0000_00FF; opb = 32'h0000_0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk++; if (alu_a !== 8'hFF || alu_b !== 8'h01 || alu_ctrl !== K_ADDC || alu_cin !== 1'b0) begin
            errs++; $display("FAIL add_first_drive got a=%h b=%h ctrl=%h cin=%b exp a=ff b=01 ctrl=%h cin=0",
                             alu_a, alu_b, alu_ctrl, alu_cin, K_ADDC); end
        for (int n = 1; n <= BYTES + 1; n++) begin
            if (ready !== 1'b0) ready_bad++;
            if (done === 1'b1) begin done_cnt++; done_at = n; end
            if (n == BYTES + 1) begin
                chk++; if (result !== 32'h0000_0100 || carry_out !== 1'b0 || zero !== 1'b0) begin
                    errs++; $display("FAIL add_value got r=%h c=%b z=%b exp r=00000100 c=0 z=0", result, carry_out, zero); end
            end
            @(posedge clk); #1;
        end
        chk++; if (done_cnt != 1 || done_at != BYTES + 1) begin
            errs++; $display("FAIL add_done_timing got count=%0d at=%0d exp count=1 at=%0d", done_cnt, done_at, BYTES + 1); end
        chk++; if (ready_bad != 0) begin errs++; $display("FAIL add_ready_busy got %0d high cycles exp 0", ready_bad); end
        chk++; if (ready !== 1'b1 || done !== 1'b0) begin
            errs++; $display("FAIL add_ready_after got ready=%b done=%b exp 1 0", ready, done); end
    endtask

    task automatic test_directed();
        logic [2:0] ops[9] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd1};
        logic [W-1:0] as[9] = '{32'hFFFF_FFFF, 32'h5, 32'h7, 32'hF0F0_A5A5, 32'hF0F0_A5A5,
                                32'hF0F0_A5A5, 32'hF0F0_A5A5, 32'h0, 32'h1234_5678};
        logic [W-1:0] bs[9] = '{32'h1, 32'h7, 32'h5, 32'h0FF0_FF00, 32'h0FF0_FF00,
                                32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0, 32'h1234_5678};
        logic [W-1:0] er[9] = '{32'h0, 32'hFFFF_FFFE, 32'h2, 32'h00F0_A500, 32'hFFF0_FFA5,
                                32'h0F0F_5A5A, 32'h0, 32'h0, 32'h0};
        logic         ec[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] r; logic c, z; int cyc;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], r, c, z, cyc);
            chk++; if (cyc > 40 || r !== er[i] || c !== ec[i] || z !== (er[i] == '0)) begin
                errs++; $display("FAIL directed_%0d got r=%h c=%b z=%b cyc=%0d exp r=%h c=%b z=%b",
                                 i, r, c, z, cyc, er[i], ec[i], er[i] == '0); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r, er; logic c, z, ec; logic [2:0] o; int cyc;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            if (i % 8 == 1) b = ~a;
            if (i % 8 == 3) b = a;
            ref_model(o, a, b, er, ec);
            run_op(o, a, b, r, c, z, cyc);
            chk++; if (cyc != BYTES + 1 || r !== er || c !== ec || z !== (er == '0)) begin
                errs++; $display("FAIL random_%0d op=%0d a=%h b=%h got r=%h c=%b z=%b cyc=%0d exp r=%h c=%b z=%b cyc=%0d",
                                 i, o, a, b, r, c, z, cyc, er, ec, er == '0, BYTES + 1); end
        end
    endtask

    task automatic test_busy_start();
        int done_cnt = 0;
        logic [W-1:0] r_at_done = '0;
        op = 3'd0; opa = 32'h0101_0101; opb = 32'h0202_0202; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (done === 1'b1) begin done_cnt++; r_at_done = result; end
            start = (n == 2 || n == 3);
            op = 3'd2; opa = 32'hFFFF_FFFF; opb = 32'h0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk++; if (done_cnt != 1 || r_at_done !== 32'h0303_0303) begin
            errs++; $display("FAIL busy_start got dones=%0d r=%h exp dones=1 r=03030303", done_cnt, r_at_done); end
    endtask

    task automatic test_reset_mid_run();
        int done_cnt = 0;
        logic [W-1:0] r; logic c, z; int cyc;
        run_op(3'd0, 32'h10, 32'h20, r, c, z, cyc);
        op = 3'd0; opa = 32'h55; opb = 32'h66; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk++; if (ready !== 1'b1 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            errs++; $display("FAIL reset_mid_run got ready=%b done=%b r=%h z=%b exp 1 0 0 1", ready, done, result, zero); end
        for (int n = 0; n < BYTES + 3; n++) begin
            if (done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        chk++; if (done_cnt != 0) begin errs++; $display("FAIL reset_no_done got %0d exp 0", done_cnt); end
    endtask

`ifdef ALU_SEQ_ABORT_EN
    task automatic test_abort();
        int done_cnt = 0;
        logic [W-1:0] r; logic c, z; int cyc;
        run_op(3'd0, 32'h1, 32'h1, r, c, z, cyc);
        chk++; if (r !== 32'h2) begin errs++; $display("FAIL abort_pre got %h exp 00000002", r); end
        op = 3'd0; opa = 32'hFF; opb = 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk++; if (ready !== 1'b1 || done !== 1'b0 || result !== 32'h2 || zero !== 1'b0) begin
            errs++; $display("FAIL abort_state got ready=%b done=%b r=%h z=%b exp 1 0 2 0", ready, done, result, zero); end
        for (int n = 0; n < BYTES + 3; n++) begin
            if (done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        chk++; if (done_cnt != 0 || result !== 32'h2) begin
            errs++; $display("FAIL abort_after got dones=%0d r=%h exp 0 2", done_cnt, result); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_timing();
        test_directed();
        test_random();
        test_busy_start();
        test_reset_mid_run();
`ifdef ALU_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end
endmodule
